axi3_rd_burst_engine: RTL and testbench

Read-side backend of the AXI3 slave. Accepts AR bursts from the slave front end, generates per-beat word addresses into a synchronous SRAM (1-cycle read latency), and returns R beats with RLAST, RID and RRESP. The write path and the master BFM are out of scope.

---
 rtl/axi3_rd_burst_engine.sv | 114 +++++++++++
 tb/tb_axi3_rd_burst_engine.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/axi3_rd_burst_engine.sv
// axi3_rd_burst_engine: AXI3 read backend, AR bursts -> per-beat SRAM reads -> R beats.
// One beat is in flight at a time; the SRAM word is sampled while in DATA.
module axi3_rd_burst_engine #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int MEM_AW     = 10
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic                  ARVALID,
    output logic                  ARREADY,
    input  logic [ADDR_WIDTH-1:0] ARADDR,
    input  logic [3:0]            ARLEN,
    input  logic [2:0]            ARSIZE,
    input  logic [1:0]            ARBURST,
    input  logic [ID_WIDTH-1:0]   ARID,
    output logic                  RVALID,
    input  logic                  RREADY,
    output logic [DATA_WIDTH-1:0] RDATA,
    output logic [1:0]            RRESP,
    output logic [ID_WIDTH-1:0]   RID,
    output logic                  RLAST,
    output logic                  mem_re,
    output logic [MEM_AW-1:0]     mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);
    localparam int B = $clog2(DATA_WIDTH / 8);

    typedef enum logic [1:0] {IDLE, ISSUE, DATA, SEND} state_t;
    state_t state, state_nxt;

    logic [ADDR_WIDTH-1:0] addr, step, total, lower, addr_inc, addr_nxt;
    logic [3:0]            len, cnt;
    logic [2:0]            size;
    logic [1:0]            burst, resp;
    logic [ID_WIDTH-1:0]   id;
    logic                  err, ar_err, ar_hs, r_hs;

    assign ar_hs  = ARVALID && ARREADY;
    assign r_hs   = RVALID && RREADY;
    assign ar_err = ARSIZE > 3'(B) || ARBURST == 2'b11 ||
                    (ARBURST == 2'b10 && !(ARLEN inside {4'd1, 4'd3, 4'd7, 4'd15}));

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  state_nxt = ar_hs ? ISSUE : IDLE;
            ISSUE: state_nxt = DATA;
            DATA:  state_nxt = SEND;
            SEND:  state_nxt = r_hs ? (RLAST ? IDLE : ISSUE) : SEND;
        endcase
    end

    // Address stepping; WRAP bounds come from the full burst span.
    always_comb begin
        step     = ADDR_WIDTH'(1) << size;
        total    = (ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size;
        lower    = addr & ~(total - ADDR_WIDTH'(1));
        addr_inc = addr + step;
        addr_nxt = burst == 2'b00 ? addr :
                   burst == 2'b10 ? (addr_inc == lower + total ? lower : addr_inc) :
                   (addr & ~(step - ADDR_WIDTH'(1))) + step;
        resp     = err ? 2'b10 : ((addr >> (B + MEM_AW)) != '0) ? 2'b11 : 2'b00;
    end

    assign mem_re   = state == ISSUE && resp == 2'b00;
    assign mem_addr = mem_re ? addr[B+MEM_AW-1:B] : '0;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state   <= IDLE;
            ARREADY <= 1'b0;
            RVALID  <= 1'b0;
            RDATA   <= '0;
            RRESP   <= 2'b00;
            RID     <= '0;
            RLAST   <= 1'b0;
            addr    <= '0;
            len     <= '0;
            size    <= '0;
            burst   <= '0;
            id      <= '0;
            cnt     <= '0;
            err     <= 1'b0;
        end else begin
            state   <= state_nxt;
            ARREADY <= state_nxt == IDLE;
            if (ar_hs) begin
                addr  <= ARADDR;
                len   <= ARLEN;
                size  <= ARSIZE;
                burst <= ARBURST;
                id    <= ARID;
                cnt   <= '0;
                err   <= ar_err;
            end
            if (state == DATA) begin
                RVALID <= 1'b1;
                RDATA  <= resp == 2'b00 ? mem_rdata : '0;
                RRESP  <= resp;
                RID    <= id;
                RLAST  <= cnt == len;
            end
            if (state == SEND && r_hs) begin
                RVALID <= 1'b0;
                if (!RLAST) begin
                    addr <= addr_nxt;
                    cnt  <= cnt + 4'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_axi3_rd_burst_engine.sv
// tb_axi3_rd_burst_engine: directed bursts against a 1-cycle SRAM model where word n holds n.
module tb_axi3_rd_burst_engine;
    logic        ACLK = 1'b0;
    logic        ARESETn = 1'b0;
    logic        ARVALID = 1'b0, ARREADY;
    logic [31:0] ARADDR = '0;
    logic [3:0]  ARLEN = '0;
    logic [2:0]  ARSIZE = '0;
    logic [1:0]  ARBURST = '0;
    logic [3:0]  ARID = '0;
    logic        RVALID, RREADY = 1'b0, RLAST;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic [3:0]  RID;
    logic        mem_re;
    logic [9:0]  mem_addr;
    logic [31:0] mem_rdata;

    axi3_rd_burst_engine dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARLEN(ARLEN),
        .ARSIZE(ARSIZE), .ARBURST(ARBURST), .ARID(ARID),
        .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP),
        .RID(RID), .RLAST(RLAST),
        .mem_re(mem_re), .mem_addr(mem_addr), .mem_rdata(mem_rdata)
    );

    always #5 ACLK = ~ACLK;

    int         re_cnt = 0;
    logic [9:0] maddr_q[$];

    // SRAM model: garbage when not read so unread beats are visible
    always @(posedge ACLK) begin
        if (mem_re) begin
            re_cnt++;
            maddr_q.push_back(mem_addr);
        end
        mem_rdata <= mem_re ? 32'(mem_addr) : 32'hDEAD_BEEF;
    end

    int          n_cmp = 0, n_bad = 0;
    int          re_base = 0, q_base = 0;
    logic [31:0] exp_data[16];
    logic [1:0]  exp_resp[16];
    logic [9:0]  exp_maddr[16];
    logic [3:0]  exp_id;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_incr(logic [9:0] w0, int n, logic [3:0] i_d);
        exp_id = i_d;
        for (int i = 0; i < n; i++) begin
            exp_data[i]  = 32'(w0 + 10'(i));
            exp_resp[i]  = 2'b00;
            exp_maddr[i] = w0 + 10'(i);
        end
    endtask

    task automatic set_err(int n, logic [3:0] i_d);
        exp_id = i_d;
        for (int i = 0; i < n; i++) begin
            exp_data[i] = '0;
            exp_resp[i] = 2'b10;
        end
    endtask

    task automatic send_ar(logic [31:0] a, logic [3:0] l, logic [2:0] s, logic [1:0] b, logic [3:0] i_d);
        int k = 0;
        re_base = re_cnt;
        q_base  = maddr_q.size();
        while (!ARREADY && k < 20) begin
            @(negedge ACLK);
            k++;
        end
        if (k == 20) check("arready_timeout", 32'(ARREADY), 32'd1);
        ARVALID = 1'b1; ARADDR = a; ARLEN = l; ARSIZE = s; ARBURST = b; ARID = i_d;
        @(posedge ACLK);
        @(negedge ACLK);
        ARVALID = 1'b0;
        check("arready_low", 32'(ARREADY), 32'd0);
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!RVALID && lat < 20) begin
            @(negedge ACLK);
            lat++;
        end
        if (!RVALID) check("rvalid_timeout", 32'd0, 32'd1);
    endtask

    task automatic get_beats(int total, int take, int stall);
        int lat;
        for (int i = 0; i < take; i++) begin
            wait_valid(lat);
            if (!RVALID) return;
            check("latency", 32'(lat), 32'd2);
            check("rdata", RDATA, exp_data[i]);
            check("rresp", 32'(RRESP), 32'(exp_resp[i]));
            check("rid", 32'(RID), 32'(exp_id));
            check("rlast", 32'(RLAST), 32'(i == total - 1));
            if (i == stall) begin
                for (int k = 0; k < 5; k++) begin
                    @(negedge ACLK);
                    check("stall_rvalid", 32'(RVALID), 32'd1);
                    check("stall_rdata", RDATA, exp_data[i]);
                    check("stall_rlast", 32'(RLAST), 32'(i == total - 1));
                end
                check("stall_re", 32'(re_cnt - re_base), 32'(i + 1));
            end
            RREADY = 1'b1;
            @(negedge ACLK);
            RREADY = 1'b0;
        end
    endtask

    task automatic end_burst(int n_re);
        @(negedge ACLK);
        check("no_extra_beat", 32'(RVALID), 32'd0);
        check("arready_back", 32'(ARREADY), 32'd1);
        check("re_count", 32'(re_cnt - re_base), 32'(n_re));
        for (int i = 0; i < n_re; i++)
            if (q_base + i < maddr_q.size())
                check("mem_addr", 32'(maddr_q[q_base+i]), 32'(exp_maddr[i]));
    endtask

    initial begin
        int lat;
        repeat (3) @(negedge ACLK);
        check("rst_arready", 32'(ARREADY), 32'd0);
        check("rst_rvalid", 32'(RVALID), 32'd0);
        check("rst_rlast", 32'(RLAST), 32'd0);
        check("rst_mem_re", 32'(mem_re), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_rdata", RDATA, 32'd0);
        check("rst_rresp", 32'(RRESP), 32'd0);
        check("rst_rid", 32'(RID), 32'd0);
        ARESETn = 1'b1;
        check("arready_pre_edge", 32'(ARREADY), 32'd0);
        @(negedge ACLK);
        check("arready_post_edge", 32'(ARREADY), 32'd1);

        // INCR 0x10, 4 beats
        set_incr(10'h004, 4, 4'd5);
        send_ar(32'h10, 4'd3, 3'd2, 2'b01, 4'd5);
        get_beats(4, 4, -1);
        end_burst(4);

        // WRAP 0x38, 4 beats
        exp_id = 4'd2;
        exp_maddr[0] = 10'h00E; exp_maddr[1] = 10'h00F; exp_maddr[2] = 10'h00C; exp_maddr[3] = 10'h00D;
        for (int i = 0; i < 4; i++) begin
            exp_data[i] = 32'(exp_maddr[i]);
            exp_resp[i] = 2'b00;
        end
        send_ar(32'h38, 4'd3, 3'd2, 2'b10, 4'd2);
        get_beats(4, 4, -1);
        end_burst(4);

        // backpressure on beat 2
        set_incr(10'h040, 4, 4'd3);
        send_ar(32'h100, 4'd3, 3'd2, 2'b01, 4'd3);
        get_beats(4, 4, 1);
        end_burst(4);

        // burst errors: oversize, reserved burst, bad WRAP length
        set_err(2, 4'd1);
        send_ar(32'h40, 4'd1, 3'd3, 2'b01, 4'd1);
        get_beats(2, 2, -1);
        end_burst(0);
        set_err(2, 4'd6);
        send_ar(32'h40, 4'd1, 3'd2, 2'b11, 4'd6);
        get_beats(2, 2, -1);
        end_burst(0);
        set_err(3, 4'd4);
        send_ar(32'h40, 4'd2, 3'd2, 2'b10, 4'd4);
        get_beats(3, 3, -1);
        end_burst(0);

        // INCR running past the SRAM: two OKAY then two DECERR
        set_incr(10'h3FE, 2, 4'd8);
        exp_resp[2] = 2'b11; exp_resp[3] = 2'b11;
        exp_data[2] = '0;    exp_data[3] = '0;
        send_ar(32'hFF8, 4'd3, 3'd2, 2'b01, 4'd8);
        get_beats(4, 4, -1);
        end_burst(2);

        // reset while beat 2 of 4 is waiting
        set_incr(10'h008, 4, 4'd7);
        send_ar(32'h20, 4'd3, 3'd2, 2'b01, 4'd7);
        get_beats(4, 1, -1);
        wait_valid(lat);
        check("beat2_latency", 32'(lat), 32'd2);
        check("beat2_rdata", RDATA, 32'd9);
        #1 ARESETn = 1'b0;
        #1;
        check("async_rvalid", 32'(RVALID), 32'd0);
        check("async_rlast", 32'(RLAST), 32'd0);
        check("async_arready", 32'(ARREADY), 32'd0);
        @(negedge ACLK);
        ARESETn = 1'b1;
        check("rel_arready_pre", 32'(ARREADY), 32'd0);
        re_base = re_cnt;
        @(negedge ACLK);
        check("rel_arready_post", 32'(ARREADY), 32'd1);
        repeat (4) @(negedge ACLK);
        check("dropped_rvalid", 32'(RVALID), 32'd0);
        check("dropped_re", 32'(re_cnt - re_base), 32'd0);

        set_incr(10'h004, 4, 4'd9);
        send_ar(32'h10, 4'd3, 3'd2, 2'b01, 4'd9);
        get_beats(4, 4, -1);
        end_burst(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
